// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage
//
// Walks the PC and assembles each 32-bit instruction from four little-endian
// byte reads on a byte-wide memory port. A finished instruction is presented
// on inst_o/pc_o with inst_valid_o and held until decode accepts it
// (inst_valid_o & ~stall_i). A taken branch/jump redirects fetch to a new PC
// from any state, dropping partial bytes and any held instruction.
//
// Ports
//   clk              clock, all state on rising edge
//   rst              synchronous, active-high reset
//   stall_i          decode cannot accept the held instruction this cycle
//   branch_i         taken branch/jump redirect (one-cycle pulse)
//   branch_target_i  redirect PC, used as-is (no alignment)
//   mem_req_o        registered byte read request
//   mem_addr_o       registered byte address of the request
//   mem_ack_i        byte read completes this cycle (counted only while
//                    mem_req_o=1)
//   mem_data_i       read byte, valid only with mem_ack_i
//   inst_valid_o     inst_o/pc_o hold a complete instruction
//   inst_o           assembled instruction
//   pc_o             address of inst_o
// ----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]  state_reg,      state_next;
  logic [1:0]  byte_cnt_reg,   byte_cnt_next;
  logic [31:0] fetch_pc_reg,   fetch_pc_next;
  logic        mem_req_reg,    mem_req_next;
  logic [31:0] mem_addr_reg,   mem_addr_next;
  logic        inst_valid_reg, inst_valid_next;
  logic [31:0] inst_reg,       inst_next;
  logic [31:0] pc_reg,         pc_next;

  // Lower three bytes of the instruction being collected; the fourth byte
  // goes straight from mem_data_i into inst_reg on the final ack.
  logic [23:0] buf_word;

  // An ack only counts against an outstanding request in FETCH; a redirect
  // in the same cycle discards it.
  logic ack_take;
  logic handoff;

  assign ack_take = (state_reg == ST_FETCH) & mem_req_reg & mem_ack_i;
  assign handoff  = inst_valid_reg & ~stall_i;

  // --------------------------------------------------------------------------
  // Byte lanes: lane gi captures the byte acked while byte_cnt == gi.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic       lane_we;

      assign lane_we = ack_take & ~branch_i & (byte_cnt_reg == 2'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= 8'h00;
        end else if (lane_we) begin
          lane_reg <= mem_data_i;
        end
      end

      assign buf_word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    fetch_pc_next   = fetch_pc_reg;
    mem_req_next    = mem_req_reg;
    mem_addr_next   = mem_addr_reg;
    inst_valid_next = inst_valid_reg;
    inst_next       = inst_reg;
    pc_next         = pc_reg;

    if (branch_i) begin
      // Redirect wins over handoff and over any same-cycle ack.
      state_next      = ST_FETCH;
      byte_cnt_next   = 2'd0;
      fetch_pc_next   = branch_target_i;
      mem_addr_next   = branch_target_i;
      mem_req_next    = 1'b1;
      inst_valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          // Request is (re)asserted the cycle after reset release; it is
          // already 1 after any other entry into FETCH.
          mem_req_next = 1'b1;
          if (ack_take) begin
            if (byte_cnt_reg == 2'd3) begin
              inst_next       = {mem_data_i, buf_word};
              pc_next         = fetch_pc_reg;
              inst_valid_next = 1'b1;
              mem_req_next    = 1'b0;
              byte_cnt_next   = 2'd0;
              state_next      = ST_HOLD;
            end else begin
              byte_cnt_next = byte_cnt_reg + 2'd1;
              mem_addr_next = mem_addr_reg + 32'd1;
            end
          end
        end
        ST_HOLD: begin
          if (handoff) begin
            inst_valid_next = 1'b0;
            fetch_pc_next   = pc_reg + 32'd4;
            mem_addr_next   = pc_reg + 32'd4;
            mem_req_next    = 1'b1;
            state_next      = ST_FETCH;
          end
        end
        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers; reset dominates redirect and ack.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FETCH;
      byte_cnt_reg   <= 2'd0;
      fetch_pc_reg   <= RESET_PC;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= RESET_PC;
      inst_valid_reg <= 1'b0;
      inst_reg       <= 32'h0;
      pc_reg         <= 32'h0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      fetch_pc_reg   <= fetch_pc_next;
      mem_req_reg    <= mem_req_next;
      mem_addr_reg   <= mem_addr_next;
      inst_valid_reg <= inst_valid_next;
      inst_reg       <= inst_next;
      pc_reg         <= pc_next;
    end
  end

  assign mem_req_o    = mem_req_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign inst_valid_o = inst_valid_reg;
  assign inst_o       = inst_reg;
  assign pc_o         = pc_reg;

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
// A transaction-level reference tracks the fetch PC, how many bytes of the
// current word have been delivered, and the presented instruction; expected
// instructions are read whole from the bench memory image.
// ----------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_data_i = 8'h00;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .pc_o            (pc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int gap_max  = 0;
  int gap_left = 0;

  // Reference model state
  logic        m_req;
  logic [31:0] m_fetch_pc;
  int          m_n;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] r;
    case (a)
      32'h100: r = 8'h13;
      32'h101: r = 8'h05;
      32'h102: r = 8'h10;
      32'h103: r = 8'h00;
      default: r = 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs applied to it.
  task automatic model_step();
    if (rst) begin
      m_req = 1'b0; m_fetch_pc = RPC; m_n = 0;
      m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'h0;
    end else if (branch_i) begin
      m_fetch_pc = branch_target_i; m_n = 0; m_req = 1'b1; m_valid = 1'b0;
    end else if (m_valid) begin
      if (!stall_i) begin
        m_valid = 1'b0; m_fetch_pc = m_pc + 32'd4; m_n = 0; m_req = 1'b1;
      end
    end else if (!m_req) begin
      m_req = 1'b1;
    end else if (mem_ack_i) begin
      if (m_n == 3) begin
        m_valid = 1'b1; m_inst = mem_word(m_fetch_pc); m_pc = m_fetch_pc;
        m_req = 1'b0; m_n = 0;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_addr;
    // While holding, the address stays on the last byte of the finished word.
    exp_addr = m_valid ? (m_pc + 32'd3) : (m_fetch_pc + 32'(m_n));
    check("mem_req", {31'd0, mem_req_o}, {31'd0, m_req});
    check("mem_addr", mem_addr_o, exp_addr);
    check("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
    check("inst", inst_o, m_inst);
    check("pc", pc_o, m_pc);
  endtask

  task automatic tick_with(input logic ack);
    mem_ack_i  = ack;
    mem_data_i = ack ? mem_byte(mem_addr_o) : 8'($urandom);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    branch_i = 1'b0;
  endtask

  task automatic tick();
    logic a;
    if (gap_left > 0) begin
      a = 1'b0;
      gap_left--;
    end else begin
      a = 1'b1;
      gap_left = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    end
    tick_with(a);
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (inst_valid_o) break;
      tick();
    end
    check("valid_timeout", {31'd0, inst_valid_o}, 32'd1);
  endtask

  initial begin
    // ---- 1: reset then fetch of 0x00100513 at 0x100 ----
    rst = 1'b1;
    tick_with(1'b1);
    tick_with(1'b1);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, RPC);
    rst = 1'b0;
    tick_with(1'b0);
    check("t1_first_req", {31'd0, mem_req_o}, 32'd1);
    check("t1_first_addr", mem_addr_o, 32'h100);
    wait_valid(20);
    check("t1_inst", inst_o, 32'h0010_0513);
    check("t1_pc", pc_o, 32'h100);
    $display("t1 fetch at 0x100: inst=%h pc=%h", inst_o, pc_o);

    // ---- 2: stall for 7 cycles, then handoff ----
    stall_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("t2_hold_inst", inst_o, 32'h0010_0513);
    check("t2_hold_req", {31'd0, mem_req_o}, 32'd0);
    stall_i = 1'b0;
    tick();
    check("t2_drop_valid", {31'd0, inst_valid_o}, 32'd0);
    check("t2_next_addr", mem_addr_o, 32'h104);
    $display("t2 stall release: next addr=%h", mem_addr_o);

    // ---- 3: redirect after two acks of a fetch ----
    tick_with(1'b1);
    tick_with(1'b1);
    branch_i = 1'b1;
    branch_target_i = 32'h2000;
    tick_with(1'b1);
    check("t3_redirect_addr", mem_addr_o, 32'h2000);
    wait_valid(20);
    check("t3_pc", pc_o, 32'h2000);
    $display("t3 redirect: pc=%h inst=%h", pc_o, inst_o);

    // ---- 4: branch + handoff + ack in the same cycle ----
    stall_i = 1'b0;
    branch_i = 1'b1;
    branch_target_i = 32'h3000;
    tick_with(1'b1);
    check("t4_valid", {31'd0, inst_valid_o}, 32'd0);
    check("t4_addr", mem_addr_o, 32'h3000);
    wait_valid(20);
    check("t4_pc", pc_o, 32'h3000);
    $display("t4 branch over handoff: pc=%h inst=%h", pc_o, inst_o);

    // ---- 5: random ack gaps and random stalls, then PC wrap ----
    gap_max = 3;
    for (int k = 0; k < 4; k++) begin
      stall_i = 1'b1;
      for (int s = $urandom_range(3, 0); s > 0; s--) tick();
      stall_i = 1'b0;
      tick();
      wait_valid(60);
      $display("t5 gapped fetch %0d: pc=%h inst=%h", k, pc_o, inst_o);
    end
    branch_i = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick();
    wait_valid(60);
    check("t5_wrap_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    check("t5_wrap_addr", mem_addr_o, 32'h0);
    wait_valid(60);
    check("t5_wrap_next_pc", pc_o, 32'h0);
    $display("t5 wrap: pc=%h inst=%h", pc_o, inst_o);
    gap_max = 0;
    gap_left = 0;

    // ---- 6: reset mid-fetch and during HOLD ----
    tick();
    tick_with(1'b1);
    tick_with(1'b1);
    rst = 1'b1;
    tick_with(1'b1);
    check("t6_mid_valid", {31'd0, inst_valid_o}, 32'd0);
    check("t6_mid_addr", mem_addr_o, RPC);
    rst = 1'b0;
    tick_with(1'b1);
    check("t6_restart_addr", mem_addr_o, RPC);
    wait_valid(20);
    stall_i = 1'b1;
    tick();
    rst = 1'b1;
    branch_i = 1'b1;
    branch_target_i = 32'h4000;
    tick_with(1'b1);
    check("t6_hold_pc", pc_o, 32'h0);
    check("t6_hold_inst", inst_o, 32'h0);
    rst = 1'b0;
    stall_i = 1'b0;
    tick_with(1'b0);
    check("t6_release_addr", mem_addr_o, RPC);
    wait_valid(20);
    check("t6_refetch_inst", inst_o, 32'h0010_0513);
    $display("t6 reset recovery: pc=%h inst=%h", pc_o, inst_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
